soc_mem_stream_reader: RTL and testbench
========================================

# soc_mem_stream_reader

Avalon-MM read master that sits directly in front of the SoC's 8192×32 single-port on-chip data memory. On a start command it reads a contiguous block of words and presents them as an Avalon-ST stream with valid/ready backpressure. It accounts for the memory's one-cycle read latency and buffers in-flight words in a small FIFO, so a stalled consumer never loses data.

## Interface
Parameters:
- ADDR_W, 13, memory word-address width (8192 words)
- DATA_W, 32, data width
- LEN_W, 14, transfer-length width; max length 8192
- FIFO_DEPTH, 4, output buffer depth in words; power of two, ≥2

Ports:
- clk  in  1  single clock for the whole block
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle command pulse; sampled only in IDLE
- base_addr  in  ADDR_W  first word address, captured on accepted start
- length  in  LEN_W  number of words, captured on accepted start
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse when the last word has been accepted downstream
- mem_chipselect  out  1  read strobe to memory
- mem_address  out  ADDR_W  word address to memory
- mem_byteenable  out  4  constant 4'hF
- mem_write  out  1  constant 0
- mem_writedata  out  DATA_W  constant 0
- mem_clken  out  1  constant 1
- mem_readdata  in  DATA_W  memory read data, valid one cycle after the address
- st_data  out  DATA_W  stream data
- st_valid  out  1  stream valid
- st_ready  in  1  stream ready
- st_last  out  1  marks the final word of the block
- checksum  out  32  see Configuration

## Operation
- FSM states: IDLE, READ, DRAIN, DONE.
- IDLE:
  - start with length≠0 → READ; capture base_addr and length; clear counters.
  - start with length=0 → DONE directly; no memory access.
- READ:
  - Issue one read per cycle while issued<length and fifo_count+inflight<FIFO_DEPTH.
  - mem_address = base_addr+issued, modulo 2^ADDR_W (0x1FFF wraps to 0x0000).
  - When issued reaches length → DRAIN.
- DRAIN: when the FIFO is empty, no read is in flight, and the last word has been accepted → DONE.
- DONE: done=1 for exactly one cycle → IDLE. busy is low in DONE.
- Stream handshake:
  - A word transfers when st_valid&st_ready.
  - st_data, st_valid and st_last hold stable while st_valid&!st_ready.
  - st_last=1 only on word number length-1.
- start while busy or in DONE is ignored.
- Simultaneous FIFO push (returning read) and pop (accepted word) in one cycle: count is unchanged and order is preserved.
- Reset mid-transfer: FSM goes to IDLE, FIFO and counters clear, any read in flight is discarded, and no done pulse is generated.

## Timing
- Reset values: busy=0, done=0, mem_chipselect=0, mem_address=0, st_valid=0, st_last=0, st_data=0, checksum=0.
- Start to first mem_chipselect: 1 cycle.
- Read data is written into the FIFO on the cycle after its chipselect.
- st_valid rises the cycle after the FIFO write: 3 cycles from start at minimum.
- With st_ready held high, throughput is 1 word/cycle.
- A length-N transfer completes with done at cycle N+3 after start.
- length=0: done 1 cycle after start.
- mem_chipselect is never asserted in IDLE, DRAIN or DONE.

## Configuration
- SOC_MEMRD_CHECKSUM_EN defined:
  - checksum accumulates the modulo-2^32 sum of every word accepted downstream.
  - checksum clears on an accepted start and is final when done pulses.
  - checksum holds its value until the next accepted start.
- SOC_MEMRD_CHECKSUM_EN undefined: checksum is tied to 0 and no adder is synthesized.

## Structure
- Package soc_memrd_pkg holds:
  - the FSM state enum (IDLE, READ, DRAIN, DONE)
  - default width constants ADDR_W, DATA_W, LEN_W
  - FIFO_DEPTH default
- Sub-module soc_memrd_fifo: synchronous FIFO of FIFO_DEPTH×DATA_W, with count output, push/pop, and flush on reset.
- Top level holds the FSM, issue/return counters, in-flight flag, and the optional checksum.

## Test plan
- Base 0x0010, length 8, memory preloaded with word=address, st_ready=1:
  - st_data runs 0x10…0x17, st_last on 0x17.
  - done at cycle 11; checksum=0x9C with the macro, 0 without.
- Base 0x1FFE, length 4:
  - addresses issued are 0x1FFE, 0x1FFF, 0x0000, 0x0001.
  - data order matches; no address exceeds 13 bits.
- Length 6 with st_ready low for 10 cycles after the first valid:
  - chipselect stops after 4 outstanding words.
  - no data is lost or duplicated; all 6 words arrive in order.
- Length 0: done pulses 1 cycle after start; mem_chipselect is never asserted; busy stays 0.
- reset asserted for one cycle mid-transfer (word 3 of 8):
  - all outputs return to reset values the next cycle; no done pulse.
  - a new start then completes normally.
- start re-pulsed while busy: it is ignored, and the original transfer completes with unchanged base and length.

Source files
------------

// File: rtl/soc_memrd_pkg.sv
// Shared types and default widths for the memory stream reader.
// Latency: n/a. Backpressure: n/a.
package soc_memrd_pkg;

    localparam int MEMRD_ADDR_W     = 13;
    localparam int MEMRD_DATA_W     = 32;
    localparam int MEMRD_LEN_W      = 14;
    localparam int MEMRD_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        DONE
    } memrd_state_t;

endpackage

// File: rtl/soc_memrd_fifo.sv
// Synchronous word FIFO with occupancy count; head word reads as zero when empty.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: none internally; the caller reserves space before pushing.
module soc_memrd_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    output logic [DATA_W-1:0]        head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    assign empty = (count == '0);
    assign head  = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            // Simultaneous push and pop leaves the count unchanged.
            case ({push, pop})
                2'b10:   count <= count + ($clog2(DEPTH) + 1)'(1);
                2'b01:   count <= count - ($clog2(DEPTH) + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/soc_mem_stream_reader.sv
// Block reader: streams length words from on-chip memory; optional sum via SOC_MEMRD_CHECKSUM_EN.
// Latency: first st_valid 3 cycles after start, done N+3 cycles after start at full rate.
// Backpressure: st_ready low stops reads once FIFO plus in-flight words fill FIFO_DEPTH.
module soc_mem_stream_reader
    import soc_memrd_pkg::*;
#(
    parameter int ADDR_W     = MEMRD_ADDR_W,
    parameter int DATA_W     = MEMRD_DATA_W,
    parameter int LEN_W      = MEMRD_LEN_W,
    parameter int FIFO_DEPTH = MEMRD_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  length,
    output logic              busy,
    output logic              done,
    output logic              mem_chipselect,
    output logic [ADDR_W-1:0] mem_address,
    output logic [3:0]        mem_byteenable,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata,
    output logic [DATA_W-1:0] st_data,
    output logic              st_valid,
    input  logic              st_ready,
    output logic              st_last,
    output logic [31:0]       checksum
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int OCC_W = CNT_W + 1;

    memrd_state_t      state;
    logic [ADDR_W-1:0] base_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  issued;
    logic [LEN_W-1:0]  acked;
    logic [LEN_W-1:0]  issued_nxt;
    logic [LEN_W-1:0]  acked_nxt;
    logic              rd_pending;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_empty;
    logic              pop;
    logic [OCC_W-1:0]  occ_nxt;
    logic              can_issue;

    assign mem_byteenable = 4'hF;
    assign mem_write      = 1'b0;
    assign mem_writedata  = '0;
    assign mem_clken      = 1'b1;

    assign st_valid = !fifo_empty;
    assign pop      = st_valid & st_ready;
    assign st_last  = st_valid && (acked == len_q - LEN_W'(1));

    assign issued_nxt = issued + LEN_W'(mem_chipselect);
    assign acked_nxt  = acked + LEN_W'(pop);

    // Words that will be buffered or still owed by memory after this edge;
    // a new read next cycle is allowed only if it still fits in the FIFO.
    assign occ_nxt   = OCC_W'(fifo_count) + OCC_W'(rd_pending)
                     + OCC_W'(mem_chipselect) - OCC_W'(pop);
    assign can_issue = (occ_nxt < OCC_W'(FIFO_DEPTH));

    soc_memrd_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (rd_pending),
        .push_data (mem_readdata),
        .pop       (pop),
        .head      (st_data),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            busy           <= 1'b0;
            done           <= 1'b0;
            mem_chipselect <= 1'b0;
            mem_address    <= '0;
            base_q         <= '0;
            len_q          <= '0;
            issued         <= '0;
            acked          <= '0;
            rd_pending     <= 1'b0;
        end else begin
            rd_pending <= mem_chipselect;
            issued     <= issued_nxt;
            acked      <= acked_nxt;
            done       <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        base_q <= base_addr;
                        len_q  <= length;
                        issued <= '0;
                        acked  <= '0;
                        if (length != '0) begin
                            state          <= READ;
                            busy           <= 1'b1;
                            mem_chipselect <= 1'b1;
                            mem_address    <= base_addr;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                READ: begin
                    // Address arithmetic truncates, so the block wraps at the top of memory.
                    mem_address <= base_q + ADDR_W'(issued_nxt);
                    if (issued_nxt == len_q) begin
                        state          <= DRAIN;
                        mem_chipselect <= 1'b0;
                    end else begin
                        mem_chipselect <= can_issue;
                    end
                end
                DRAIN: begin
                    if (acked_nxt == len_q) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef SOC_MEMRD_CHECKSUM_EN
    logic [31:0] sum_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sum_q <= '0;
        end else if (state == IDLE && start) begin
            sum_q <= '0;
        end else if (pop) begin
            sum_q <= sum_q + 32'(st_data);
        end
    end

    assign checksum = sum_q;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_soc_mem_stream_reader.sv
// Directed bench for soc_mem_stream_reader against a word=address memory model.
module tb_soc_mem_stream_reader;

    logic        clk;
    logic        reset;
    logic        start;
    logic [12:0] base_addr;
    logic [13:0] length;
    logic        busy;
    logic        done;
    logic        mem_chipselect;
    logic [12:0] mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic        mem_clken;
    logic [31:0] mem_readdata;
    logic [31:0] st_data;
    logic        st_valid;
    logic        st_ready;
    logic        st_last;
    logic [31:0] checksum;

    logic [31:0] mem_model [8192];
    logic [31:0] data_q [$];
    logic        last_q [$];
    logic [12:0] addr_q [$];

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int start_cyc = 0;
    int done_cyc = 0;
    int done_cnt = 0;
    int done_base = 0;
    int busy_cnt = 0;

`ifdef SOC_MEMRD_CHECKSUM_EN
    localparam logic [31:0] SUM_T1 = 32'h9C;
    localparam logic [31:0] SUM_T6 = 32'h1EA;
`else
    localparam logic [31:0] SUM_T1 = 32'h0;
    localparam logic [31:0] SUM_T6 = 32'h0;
`endif

    soc_mem_stream_reader dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .base_addr      (base_addr),
        .length         (length),
        .busy           (busy),
        .done           (done),
        .mem_chipselect (mem_chipselect),
        .mem_address    (mem_address),
        .mem_byteenable (mem_byteenable),
        .mem_write      (mem_write),
        .mem_writedata  (mem_writedata),
        .mem_clken      (mem_clken),
        .mem_readdata   (mem_readdata),
        .st_data        (st_data),
        .st_valid       (st_valid),
        .st_ready       (st_ready),
        .st_last        (st_last),
        .checksum       (checksum)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Single-port memory with one-cycle read latency.
    always @(posedge clk) begin
        if (mem_chipselect) mem_readdata <= mem_model[mem_address];
    end

    always @(negedge clk) begin
        if (mem_chipselect) addr_q.push_back(mem_address);
        if (st_valid && st_ready) begin
            data_q.push_back(st_data);
            last_q.push_back(st_last);
        end
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
        if (busy) busy_cnt = busy_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_logs();
        data_q.delete();
        last_q.delete();
        addr_q.delete();
        busy_cnt  = 0;
        done_base = done_cnt;
    endtask

    task automatic kick(input logic [12:0] b, input logic [13:0] l);
        @(posedge clk); #1;
        base_addr = b;
        length    = l;
        start     = 1'b1;
        start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done_cnt == done_base && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", done_cnt - done_base, 1);
    endtask

    task automatic check_reset_vals(input string pfx);
        chk({pfx, "_busy"}, busy, 0);
        chk({pfx, "_done"}, done, 0);
        chk({pfx, "_cs"}, mem_chipselect, 0);
        chk({pfx, "_addr"}, mem_address, 0);
        chk({pfx, "_valid"}, st_valid, 0);
        chk({pfx, "_last"}, st_last, 0);
        chk({pfx, "_data"}, st_data, 0);
        chk({pfx, "_sum"}, checksum, 0);
    endtask

    task automatic check_stream(input logic [12:0] b, input int n);
        logic [12:0] ea;
        chk("n_words", data_q.size(), n);
        chk("n_reads", addr_q.size(), n);
        for (int i = 0; i < n; i++) begin
            ea = b + 13'(i);
            chk($sformatf("addr[%0d]", i), (i < addr_q.size()) ? addr_q[i] : 13'h0, ea);
            chk($sformatf("data[%0d]", i), (i < data_q.size()) ? data_q[i] : 32'hDEADBEEF, {19'h0, ea});
            chk($sformatf("last[%0d]", i), (i < last_q.size()) ? last_q[i] : 1'bx, (i == n - 1));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        for (int i = 0; i < 8192; i++) mem_model[i] = i;
        reset     = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        length    = '0;
        st_ready  = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_vals("rst");
        chk("rst_be", mem_byteenable, 4'hF);
        chk("rst_clken", mem_clken, 1);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);

        // Basic block: base 0x10, length 8, full rate.
        clear_logs();
        kick(13'h0010, 14'd8);
        wait_done(100);
        chk("t1_latency", done_cyc - start_cyc, 11);
        chk("t1_busy_cycles", busy_cnt, 10);
        check_stream(13'h0010, 8);
        chk("t1_sum", checksum, SUM_T1);
        repeat (3) @(posedge clk);

        // Wrap at the top of memory.
        clear_logs();
        kick(13'h1FFE, 14'd4);
        wait_done(100);
        chk("t2_latency", done_cyc - start_cyc, 7);
        check_stream(13'h1FFE, 4);
        repeat (3) @(posedge clk);

        // Backpressure: consumer stalls 10 cycles from the first valid.
        clear_logs();
        st_ready = 1'b0;
        kick(13'h0100, 14'd6);
        n = 0;
        @(negedge clk);
        while (!st_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("t3_valid_seen", st_valid, 1);
        repeat (10) @(posedge clk);
        #1;
        chk("t3_outstanding", addr_q.size(), 4);
        chk("t3_none_taken", data_q.size(), 0);
        st_ready = 1'b1;
        wait_done(100);
        check_stream(13'h0100, 6);
        repeat (3) @(posedge clk);

        // Zero length.
        clear_logs();
        kick(13'h0005, 14'd0);
        wait_done(20);
        chk("t4_latency", done_cyc - start_cyc, 1);
        chk("t4_no_reads", addr_q.size(), 0);
        chk("t4_busy_cycles", busy_cnt, 0);
        chk("t4_sum", checksum, 0);
        repeat (3) @(posedge clk);

        // Reset while word 3 of 8 is on the stream.
        clear_logs();
        kick(13'h0020, 14'd8);
        n = 0;
        while (data_q.size() < 3 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("t5_words_before_reset", data_q.size(), 3);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check_reset_vals("t5");
        repeat (15) @(posedge clk);
        @(negedge clk);
        chk("t5_no_done", done_cnt - done_base, 0);
        chk("t5_idle_busy", busy, 0);
        clear_logs();
        kick(13'h0040, 14'd3);
        wait_done(100);
        chk("t5_latency", done_cyc - start_cyc, 6);
        check_stream(13'h0040, 3);
        repeat (3) @(posedge clk);

        // A second start while busy must not disturb the running block.
        clear_logs();
        kick(13'h0060, 14'd5);
        @(posedge clk); #1;
        base_addr = 13'h0200;
        length    = 14'd2;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(100);
        chk("t6_latency", done_cyc - start_cyc, 8);
        check_stream(13'h0060, 5);
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("t6_single_done", done_cnt - done_base, 1);
        chk("t6_sum_held", checksum, SUM_T6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
